dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//   Data-memory responder serving the core's load/store requests over a valid/ready request
//   channel and a one-cycle response pulse. Holds the word-addressed data RAM internally.
//   Handles RISC-V LB/LH/LW/LBU/LHU and SB/SH/SW width rules, with sign/zero extension.
//   Performs sub-word stores as read-modify-write. Sits between the datapath's ALU
//   address/store-data outputs and the register-file write-back mux.
// PARAMETERS
//   ADDR_W     14            word-index width; RAM depth = 2**ADDR_W words of 32 bits
//   BASE_ADDR  32'h0000_0000 byte address of word 0; must be 4-byte aligned
// PORTS
//   clk         in   1   system clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   req_valid   in   1   request present
//   req_ready   out  1   responder can accept; high only in IDLE
//   req_we      in   1   1 = store, 0 = load
//   req_addr    in   32  byte address
//   req_wdata   in   32  store data; low byte/half used for SB/SH
//   req_funct3  in   3   access width/sign, RISC-V encoding
//   rsp_valid   out  1   one-cycle pulse; response fields valid this cycle only
//   rsp_rdata   out  32  load result, extended; 0 for stores and errors
//   rsp_err     out  1   request rejected; no RAM state changed
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0.
//     RAM contents are not cleared. A reset mid-request aborts it with no response.
//     A store aborted before WRITE leaves RAM unchanged.
//   - Accept: on a clk edge where req_valid & req_ready. All req_* fields are latched then.
//     Inputs are ignored while req_ready=0. There is no response back-pressure: the core
//     stalls until rsp_valid.
//   - FSM states: IDLE -> READ -> (store: WRITE) -> RESP -> IDLE.
//     Error requests go IDLE -> RESP directly.
//   - READ: synchronous RAM read of word (addr-BASE_ADDR)>>2; data is available the next cycle.
//   - WRITE (stores only): write the merged word. For SW, the full req_wdata is written.
//     For SB/SH, the read word is written back with only the addressed byte or halfword
//     replaced.
//   - RESP: rsp_valid=1 for exactly one cycle; req_ready returns to 1 in the following cycle.
//   - Latency from accept edge to rsp_valid: load = 2 cycles, store = 3 cycles, error = 1 cycle.
//     Throughput is one request per 3 cycles (loads) or 4 cycles (stores).
//   - Load extraction by funct3 and byte offset addr[1:0] (little-endian):
//       000 LB  = sign-extend byte[off]
//       001 LH  = sign-extend half[off[1]]
//       010 LW  = word
//       100 LBU = zero-extend byte[off]
//       101 LHU = zero-extend half[off[1]]
//   - Store encodings: 000 SB, 001 SH, 010 SW.
//   - Errors (rsp_err=1, rsp_rdata=0, no write):
//       * address outside [BASE_ADDR, BASE_ADDR + 4*2**ADDR_W), computed in 33-bit
//         arithmetic so no wrap-around occurs;
//       * load funct3 in {011, 110, 111};
//       * store funct3 > 010.
//   - On stores, rsp_rdata=0. Outside RESP, rsp_rdata and rsp_err hold 0.
//   - A request accepted in the same edge that RESP ends is impossible, because
//     req_ready=0 during RESP.
// CONFIGURATION
//   DMEM_MISALIGN_ERR_EN
//     defined: LH/LHU/SH with addr[0]!=0, and LW/SW with addr[1:0]!=0, return rsp_err=1
//              after 1 cycle, with no RAM access.
//     undefined: misaligned offsets are silently aligned down (LH/SH uses addr[1];
//                LW/SW ignore addr[1:0]), and rsp_err is raised only for range and
//                funct3 errors.
// TESTING
//   1. Reset, then SW addr=0x10 data=0xDEADBEEF, then LW 0x10
//      -> store rsp_valid 3 cycles after accept with rdata=0; load rdata=0xDEADBEEF
//         2 cycles after accept.
//   2. Continuing from 1, SB addr=0x11 data=0x000000A5, then LW 0x10 -> 0xDEADA5EF.
//      Then LB 0x11 -> 0xFFFFFFA5, and LBU 0x11 -> 0x000000A5.
//   3. Continuing from 2, SH addr=0x12 data=0x00008001, then LH 0x12 -> 0xFFFF8001;
//      LHU 0x12 -> 0x00008001; LW 0x10 -> 0x8001A5EF.
//   4. LW addr=BASE_ADDR+4*2**ADDR_W, and a load with funct3=011
//      -> rsp_err=1, rdata=0, 1-cycle latency; a follow-up LW 0x10 is unchanged.
//   5. LW 0x12 with the macro defined -> rsp_err=1. With the macro undefined -> returns
//      the word at 0x10, rsp_err=0.
//   6. Hold req_valid high continuously with back-to-back requests -> req_ready low from
//      accept through RESP. Assert rst_n=0 during a store's READ state -> outputs go to
//      reset values and RAM at that address is unchanged.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready load/store requests, internal word RAM,
// RISC-V sub-word extraction and read-modify-write stores. Optional macro: DMEM_MISALIGN_ERR_EN.
module dmem_responder #(
  parameter int          ADDR_W    = 14,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t            state;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       ram_q;
  logic [31:0]       mem [2**ADDR_W];

  logic [32:0] addr_diff;
  logic        in_range;
  logic        funct3_bad;
  logic        misalign;
  logic        req_err;
  logic [31:0] merged;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_val;

  // The 33-bit difference keeps addresses below BASE_ADDR from wrapping into range.
  always_comb begin
    addr_diff  = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    in_range   = !addr_diff[32] && ((addr_diff[31:0] >> (ADDR_W + 2)) == 32'd0);
    funct3_bad = req_we ? (req_funct3 > 3'b010)
                        : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
`ifdef DMEM_MISALIGN_ERR_EN
    misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
               ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    req_err = !in_range || funct3_bad || misalign;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      idx_q    <= '0;
      wdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            off_q    <= addr_diff[1:0];
            idx_q    <= addr_diff[ADDR_W+1:2];
            wdata_q  <= req_wdata;
            err_q    <= req_err;
            state    <= req_err ? RESP : READ;
          end
        end
        READ:    state <= we_q ? WRITE : RESP;
        WRITE:   state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // RAM is not reset; a reset during WRITE drops the state and so the write enable.
  always_ff @(posedge clk) begin
    if (state == READ)
      ram_q <= mem[idx_q];
    if (state == WRITE)
      mem[idx_q] <= merged;
  end

  always_comb begin
    merged = ram_q;
    case (funct3_q[1:0])
      2'b00: begin
        case (off_q)
          2'd0:    merged[7:0]   = wdata_q[7:0];
          2'd1:    merged[15:8]  = wdata_q[7:0];
          2'd2:    merged[23:16] = wdata_q[7:0];
          default: merged[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (off_q[1]) merged[31:16] = wdata_q[15:0];
        else          merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    case (off_q)
      2'd0:    sel_byte = ram_q[7:0];
      2'd1:    sel_byte = ram_q[15:8];
      2'd2:    sel_byte = ram_q[23:16];
      default: sel_byte = ram_q[31:24];
    endcase
    sel_half = off_q[1] ? ram_q[31:16] : ram_q[15:0];
    case (funct3_q)
      3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_val = {24'd0, sel_byte};
      3'b101:  load_val = {16'd0, sel_half};
      default: load_val = ram_q;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = (state == RESP) && err_q;
  assign rsp_rdata = ((state == RESP) && !err_q && !we_q) ? load_val : 32'd0;

endmodule
